// File: rtl/io_wait_pkg.sv
// io_wait_pkg: shared state encoding and default wait/timeout constants for the I/O wait-state DTACK source.
package io_wait_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, WAIT, READY_WAIT, ACK, ERR} stateT;
  localparam int DEF_READ_WAITS = 3;
  localparam int DEF_WRITE_WAITS = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/wait_timeout_counter.sv
// wait_timeout_counter: loadable counter with clear/load/decrement/increment and a terminal-count flag.
module wait_timeout_counter #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] TERM = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  input  logic             inc,
  output logic             term
);
  logic [CNT_W-1:0] count;
  // Decrement saturates at zero so a zero-wait load can sit through SETUP.
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (load) count <= loadVal;
    else if (dec && count != '0) count <= count - CNT_W'(1);
    else if (inc) count <= count + CNT_W'(1);
  assign term = count == TERM;
endmodule

// File: rtl/io_wait_state_dtack.sv
// io_wait_state_dtack: wait-state sequencer and DTACK source for a slow I/O peripheral on the 68k bus.
// Define IO_WAIT_TIMEOUT_EN to add the timeout counter, ERR state and bus-error output.
module io_wait_state_dtack import io_wait_pkg::*; #(
  parameter int READ_WAITS = DEF_READ_WAITS,
  parameter int WRITE_WAITS = DEF_WRITE_WAITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W = 8
) (
  input  logic Clock,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic RW,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic Select_H,
  input  logic DeviceReady_H,
  output logic Dtack_L,
  output logic Berr_L,
  output logic DeviceCS_H,
  output logic DeviceRd_H,
  output logic DeviceWr_H,
  output logic Busy_H
);
  stateT state, nextState;
  logic rwQ, rwNext, start, waitDone, timedOut;
  if (READ_WAITS >= 2**CNT_W || WRITE_WAITS >= 2**CNT_W || TIMEOUT_CYCLES >= 2**CNT_W) begin : gBadWidth
    $error("CNT_W too narrow for wait/timeout counts");
  end
  assign start = state == IDLE && !AS_L && Select_H && (!UDS_L || !LDS_L);
  assign rwNext = start ? RW : rwQ;
  // Decrementing through SETUP makes the count hit zero exactly when N wait cycles are done.
  wait_timeout_counter #(.CNT_W(CNT_W), .TERM('0)) waitCnt (
    .clk(Clock),
    .rst(Reset_H),
    .clr(1'b0),
    .load(start),
    .loadVal(RW ? CNT_W'(READ_WAITS) : CNT_W'(WRITE_WAITS)),
    .dec(state == SETUP || state == WAIT),
    .inc(1'b0),
    .term(waitDone)
  );
`ifdef IO_WAIT_TIMEOUT_EN
  wait_timeout_counter #(.CNT_W(CNT_W), .TERM(CNT_W'(TIMEOUT_CYCLES))) timeoutCnt (
    .clk(Clock),
    .rst(Reset_H),
    .clr(start),
    .load(1'b0),
    .loadVal('0),
    .dec(1'b0),
    .inc(state == SETUP || state == WAIT || state == READY_WAIT),
    .term(timedOut)
  );
`else
  assign timedOut = 1'b0;
  assign Berr_L = 1'b1;
`endif
  // Abort beats everything; ready beats timeout.
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:         nextState = start ? SETUP : IDLE;
      SETUP, WAIT:  nextState = AS_L ? IDLE : timedOut ? ERR : waitDone ? READY_WAIT : WAIT;
      READY_WAIT:   nextState = AS_L ? IDLE : DeviceReady_H ? ACK : timedOut ? ERR : READY_WAIT;
      ACK, ERR:     nextState = AS_L ? IDLE : state;
      default:      nextState = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset_H)
    if (Reset_H) begin
      state <= IDLE;
      rwQ <= 1'b0;
      Dtack_L <= 1'b1;
`ifdef IO_WAIT_TIMEOUT_EN
      Berr_L <= 1'b1;
`endif
      DeviceCS_H <= 1'b0;
      DeviceRd_H <= 1'b0;
      DeviceWr_H <= 1'b0;
      Busy_H <= 1'b0;
    end else begin
      state <= nextState;
      rwQ <= rwNext;
      Dtack_L <= nextState != ACK;
`ifdef IO_WAIT_TIMEOUT_EN
      Berr_L <= nextState != ERR;
`endif
      DeviceCS_H <= nextState inside {SETUP, WAIT, READY_WAIT, ACK};
      DeviceRd_H <= rwNext && nextState inside {WAIT, READY_WAIT, ACK};
      DeviceWr_H <= !rwNext && nextState inside {WAIT, READY_WAIT, ACK};
      Busy_H <= nextState != IDLE;
    end
endmodule

// File: tb/tb_io_wait_state_dtack.sv
// tb_io_wait_state_dtack: randomized bus cycles checked against a per-access timeline model.
module tb_io_wait_state_dtack;
  localparam int RD_N = 3;
  localparam int WR_N = 0;
  localparam int TO = 10;
  localparam logic [5:0] IDLE_O = 6'b110000;
  logic Clock = 0, Reset_H = 0, AS_L = 1, RW = 1, UDS_L = 1, LDS_L = 1, Select_H = 0, DeviceReady_H = 0;
  logic Dtack_L, Berr_L, DeviceCS_H, DeviceRd_H, DeviceWr_H, Busy_H;
  int nCmp = 0, nBad = 0, txnNo = 0;
  always #5 Clock = ~Clock;
  io_wait_state_dtack #(.READ_WAITS(RD_N), .WRITE_WAITS(WR_N), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .Clock(Clock), .Reset_H(Reset_H), .AS_L(AS_L), .RW(RW), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .Select_H(Select_H), .DeviceReady_H(DeviceReady_H), .Dtack_L(Dtack_L), .Berr_L(Berr_L),
    .DeviceCS_H(DeviceCS_H), .DeviceRd_H(DeviceRd_H), .DeviceWr_H(DeviceWr_H), .Busy_H(Busy_H)
  );
  function automatic logic [5:0] outs();
    return {Dtack_L, Berr_L, DeviceCS_H, DeviceRd_H, DeviceWr_H, Busy_H};
  endfunction
  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got={dtk,berr,cs,rd,wr,busy}=%b exp=%b", tag, got, exp);
    end
  endtask
  // One bus cycle: AS_L low for edges 0..len-1 (relative to the start edge), high afterwards.
  // Ready stays low from READY_WAIT entry for d cycles; timeout fires at edge TO+1 in the timeout build.
  task automatic runTxn(input bit sel, input bit uds, input bit lds, input bit rw, input int len, input int d, input int gap);
    int n = rw ? RD_N : WR_N;
    int eR = n + 2 + d;
    int tR;
    bit valid, ack, err, act, inErr;
`ifdef IO_WAIT_TIMEOUT_EN
    tR = TO + 1;
`else
    tR = 1 << 20;
`endif
    valid = sel && (!uds || !lds);
    ack = eR < len && eR <= tR;
    err = !ack && tR < len;
    for (int j = 0; j <= len + gap; j++) begin
      AS_L = j >= len;
      if (j == 0 || !valid) begin
        Select_H = sel; UDS_L = uds; LDS_L = lds; RW = rw;
      end else begin
        Select_H = 1'($urandom); UDS_L = 1'($urandom); LDS_L = 1'($urandom); RW = 1'($urandom);
      end
      DeviceReady_H = j < n + 2 ? 1'($urandom) : j >= eR;
      @(posedge Clock);
      #1;
      act = valid && j < len;
      inErr = err && j >= tR;
      check($sformatf("txn%0d_e%0d", txnNo, j), outs(),
            {!(act && ack && j >= eR), !(act && inErr), act && !inErr,
             act && !inErr && j >= 1 && rw, act && !inErr && j >= 1 && !rw, act});
    end
    txnNo++;
  endtask
  initial begin
    #2 Reset_H = 1;
    #1 check("rstAsync0", outs(), IDLE_O);
    repeat (2) @(posedge Clock);
    #1 check("rstHeld", outs(), IDLE_O);
    Reset_H = 0;
    runTxn(1, 1, 0, 1, 10, 0, 2);
    runTxn(1, 0, 1, 0, 12, 4, 1);
    runTxn(0, 0, 0, 1, 8, 0, 1);
    runTxn(1, 0, 0, 1, 3, 0, 1);
    runTxn(1, 1, 0, 1, 16, 40, 2);
    runTxn(1, 0, 1, 0, 1, 0, 0);
    for (int t = 0; t < 60; t++)
      runTxn($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(1, 20), $urandom_range(0, 4) == 0 ? 40 : $urandom_range(0, 6), $urandom_range(0, 3));
    AS_L = 0; Select_H = 1; LDS_L = 0; UDS_L = 1; RW = 1; DeviceReady_H = 1;
    for (int j = 0; j <= 5; j++) begin
      @(posedge Clock);
      #1;
    end
    check("preRstAck", outs(), 6'b011101);
    #1 Reset_H = 1; AS_L = 1;
    #1 check("rstMidAck", outs(), IDLE_O);
    #2 Reset_H = 0;
    runTxn(1, 1, 0, 1, 8, 0, 2);
    for (int t = 0; t < 5; t++)
      runTxn(1, 1'($urandom), 0, 1'($urandom), $urandom_range(1, 20), $urandom_range(0, 6), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
